// File: rtl/bcd_link_pkg.sv
// Shared definitions for the serial BCD display link (transmitter and receiver).
// Bit order on the wire: MSB first, so digit 3 (bits [15:12]) is sent first.
package bcd_link_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = DIGITS * NIBBLE_W;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } rx_state_e;

    // A BCD digit is only legal in the range 0..9.
    function automatic logic nibble_bad(input logic [NIBBLE_W-1:0] nib);
        return (nib > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational range check of a packed BCD word: flags any digit above 9.
// Shared with the display_out assertion checker.
module bcd_digit_check
    import bcd_link_pkg::*;
#(
    parameter int N_DIGITS = DIGITS
) (
    input  logic [N_DIGITS*NIBBLE_W-1:0] word,
    output logic                         any_bad
);

    // OR-reduce the per-digit range violations.
    always_comb begin
        any_bad = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (nibble_bad(word[d*NIBBLE_W +: NIBBLE_W])) begin
                any_bad = 1'b1;
            end else begin
                any_bad = any_bad;
            end
        end
    end

endmodule

// File: rtl/bcd_serial_rx.sv
// Receiver for the serial BCD display link: deserialises one WORD_W-bit frame,
// checks its length and digit range, and presents it with a one-cycle strobe.
module bcd_serial_rx
    import bcd_link_pkg::*;
#(
    parameter int DIGITS_P = DIGITS,
    parameter int WORD_W_P = WORD_W,
    parameter int CNT_W_P  = CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                data_in,
    input  logic                sending_data,
    output logic [WORD_W_P-1:0] bcd_out,
    output logic                valid,
    output logic                frame_err,
    output logic                bcd_err
);

    localparam logic [CNT_W_P-1:0] FULL_CNT = CNT_W_P'(WORD_W_P);
    localparam logic [CNT_W_P-1:0] ONE_CNT  = CNT_W_P'(1);
    localparam logic [CNT_W_P-1:0] ZERO_CNT = {CNT_W_P{1'b0}};

    rx_state_e           state_r;
    rx_state_e           state_s;
    logic [CNT_W_P-1:0]  count_r;
    logic [CNT_W_P-1:0]  count_s;
    logic [WORD_W_P-1:0] shift_r;
    logic [WORD_W_P-1:0] shift_s;
    logic [WORD_W_P-1:0] bcd_out_r;
    logic                valid_r;
    logic                frame_err_r;
    logic                bcd_err_r;
    logic                load_s;
    logic                ferr_s;
    logic                any_bad_s;

    bcd_digit_check #(
        .N_DIGITS (DIGITS_P)
    ) u_digit_check (
        .word    (shift_r),
        .any_bad (any_bad_s)
    );

    // Frame FSM: counts bits while the qualifier is high and judges the frame when it drops.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        shift_s = shift_r;
        load_s  = 1'b0;
        ferr_s  = 1'b0;
        if (!enable) begin
            // Disabled: drop any partial frame silently and ignore the line.
            state_s = IDLE;
            count_s = ZERO_CNT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sending_data) begin
                        shift_s = {shift_r[WORD_W_P-2:0], data_in};
                        count_s = ONE_CNT;
                        state_s = SHIFT;
                    end else begin
                        count_s = ZERO_CNT;
                    end
                end
                SHIFT: begin
                    if (sending_data) begin
                        if (count_r < FULL_CNT) begin
                            shift_s = {shift_r[WORD_W_P-2:0], data_in};
                            count_s = count_r + ONE_CNT;
                        end else begin
                            state_s = OVERRUN;
                        end
                    end else begin
                        if (count_r == FULL_CNT) begin
                            load_s = 1'b1;
                        end else begin
                            ferr_s = 1'b1;
                        end
                        state_s = IDLE;
                        count_s = ZERO_CNT;
                    end
                end
                OVERRUN: begin
                    if (!sending_data) begin
                        ferr_s  = 1'b1;
                        state_s = IDLE;
                        count_s = ZERO_CNT;
                    end else begin
                        state_s = OVERRUN;
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = ZERO_CNT;
                end
            endcase
        end
    end

    // State, strobes and the output word; bcd_err is captured with the word it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= ZERO_CNT;
            shift_r     <= {WORD_W_P{1'b0}};
            bcd_out_r   <= {WORD_W_P{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            bcd_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            shift_r     <= shift_s;
            valid_r     <= load_s;
            frame_err_r <= ferr_s;
            if (load_s) begin
                bcd_out_r <= shift_r;
                bcd_err_r <= any_bad_s;
            end else begin
                bcd_out_r <= bcd_out_r;
                bcd_err_r <= bcd_err_r;
            end
        end
    end

    assign bcd_out   = bcd_out_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign bcd_err   = bcd_err_r;

endmodule

// File: tb/tb_bcd_serial_rx.sv
// Self-checking bench for bcd_serial_rx: table of frames driven MSB first,
// strobes checked against a scoreboard queue, plus a few hand-written sequences.
module tb_bcd_serial_rx;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        data_in;
    logic        sending_data;
    logic [15:0] bcd_out;
    logic        valid;
    logic        frame_err;
    logic        bcd_err;

    int total;
    int bad;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          rst_at;
        int          en_off_at;
        int          exp_kind;   // 0 none, 1 valid, 2 frame_err
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          kind;
        logic [15:0] word;
        logic        err;
    } sb_t;

    vec_t vecs[13];
    sb_t  q[$];

    bcd_serial_rx dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .data_in      (data_in),
        .sending_data (sending_data),
        .bcd_out      (bcd_out),
        .valid        (valid),
        .frame_err    (frame_err),
        .bcd_err      (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe monitor: every valid/frame_err pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (valid === 1'b1 || frame_err === 1'b1) begin
            chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, frame_err, valid}, 32'd0);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("strobe_kind", (valid === 1'b1) ? 32'd1 : 32'd2, e.kind);
                if (e.kind == 1) begin
                    chk("sb_word", {16'd0, bcd_out}, {16'd0, e.word});
                    chk("sb_bcd_err", {31'd0, bcd_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic send(input vec_t v);
        logic [15:0] w;
        w = v.word;
        if (v.exp_kind != 0) begin
            sb_t e;
            e.kind = v.exp_kind;
            e.word = v.exp_out;
            e.err  = v.exp_err;
            q.push_back(e);
        end
        for (int i = 0; i < v.nbits; i++) begin
            sending_data = 1'b1;
            data_in      = (i < 16) ? w[15-i] : 1'b1;
            rst          = (i == v.rst_at);
            enable       = (i != v.en_off_at);
            @(posedge clk);
            #1;
            if (rst || !enable) break;
        end
        rst          = 1'b0;
        enable       = 1'b1;
        sending_data = 1'b0;
        data_in      = 1'b0;
        @(posedge clk);
        #1;
        // One cycle after the low edge: strobe latency and held outputs.
        chk("valid_at_latency", {31'd0, valid}, {31'd0, v.exp_kind == 1});
        chk("ferr_at_latency", {31'd0, frame_err}, {31'd0, v.exp_kind == 2});
        chk("bcd_out", {16'd0, bcd_out}, {16'd0, v.exp_out});
        chk("bcd_err", {31'd0, bcd_err}, {31'd0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        //         word      nbits rst en  kind out       err
        vecs[0]  = '{16'h8888, 16, -1, -1, 1, 16'h8888, 1'b0};
        vecs[1]  = '{16'h1234, 16, -1, -1, 1, 16'h1234, 1'b0};
        vecs[2]  = '{16'h0987, 16, -1, -1, 1, 16'h0987, 1'b0};
        vecs[3]  = '{16'h5555, 16, -1, -1, 1, 16'h5555, 1'b0};
        vecs[4]  = '{16'hFFFF, 15, -1, -1, 2, 16'h5555, 1'b0};
        vecs[5]  = '{16'h1111, 17, -1, -1, 2, 16'h5555, 1'b0};
        vecs[6]  = '{16'h12A4, 16, -1, -1, 1, 16'h12A4, 1'b1};
        vecs[7]  = '{16'h0000, 16, -1, -1, 1, 16'h0000, 1'b0};
        vecs[8]  = '{16'h9999, 16,  8, -1, 0, 16'h0000, 1'b0};
        vecs[9]  = '{16'h4321, 16, -1, -1, 1, 16'h4321, 1'b0};
        vecs[10] = '{16'h7777, 16, -1,  5, 0, 16'h4321, 1'b0};
        vecs[11] = '{16'h99F9, 16, -1, -1, 1, 16'h99F9, 1'b1};
        vecs[12] = '{16'h9999, 16, -1, -1, 1, 16'h9999, 1'b0};

        rst          = 1'b1;
        enable       = 1'b1;
        sending_data = 1'b0;
        data_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bcd_out", {16'd0, bcd_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_bcd_err", {31'd0, bcd_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 13; k++) begin
            send(vecs[k]);
        end

        // Line activity while disabled is ignored entirely.
        enable       = 1'b0;
        sending_data = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = i[0];
            @(posedge clk);
            #1;
        end
        enable       = 1'b1;
        sending_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("disabled_bcd_out", {16'd0, bcd_out}, 32'h0000_9999);
        chk("disabled_no_valid", {31'd0, valid}, 32'd0);

        // Good frame then a 1-bit runt: runt must flag frame_err only.
        vecs[0] = '{16'h2468, 16, -1, -1, 1, 16'h2468, 1'b0};
        send(vecs[0]);
        vecs[1] = '{16'h8000, 1, -1, -1, 2, 16'h2468, 1'b0};
        send(vecs[1]);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
